// File: rtl/gpr_file_mp_if.sv
// Bus interface for gpr_file_mp: two read ports, two write ports, reserve
// request and the scoreboard/busy status returned by the register file.
interface gpr_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              we0;
  logic [ADDR_W-1:0] wa0;
  logic [DATA_W-1:0] wd0;
  logic              we1;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd1;
  logic              res_en;
  logic [ADDR_W-1:0] res_addr;
  logic              pend1;
  logic              pend2;
  logic              busy;

  // Pipeline side driving addresses, writes and reserves
  modport master (
    output rs, rt, we0, wa0, wd0, we1, wa1, wd1, res_en, res_addr,
    input  rd1, rd2, pend1, pend2, busy
  );

  // Register file side
  modport slave (
    input  rs, rt, we0, wa0, wd0, we1, wa1, wd1, res_en, res_addr,
    output rd1, rd2, pend1, pend2, busy
  );
endinterface

// File: rtl/gpr_file_mp.sv
// gpr_file_mp: 2-read / 2-write general-purpose register file with a
// post-reset clearing walk and a per-register pending scoreboard.
// Optional write-through forwarding is enabled by defining GPR_BYPASS_EN.
//
// state   | meaning
// S_CLEAR | walking clr_ptr over every entry writing 0; busy=1, ports blocked
// S_IDLE  | normal operation: reads, writes, reserves
module gpr_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  gpr_file_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic ZR = (ZERO_REG != 0);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              busy_q;
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr0_ok;
  logic wr1_ok;
  logic res_ok;

  // Qualify writes/reserves: dropped while clearing and, with ZERO_REG, at entry 0
  always_comb begin
    wr0_ok = (state_q == S_IDLE) && bus.we0    && !(ZR && (bus.wa0 == '0));
    wr1_ok = (state_q == S_IDLE) && bus.we1    && !(ZR && (bus.wa1 == '0));
    res_ok = (state_q == S_IDLE) && bus.res_en && !(ZR && (bus.res_addr == '0));
  end

  // Scoreboard next state: writes retire producers, a same-cycle reserve wins
  always_comb begin
    pend_d = pend_q;
    if (wr0_ok) pend_d[bus.wa0] = 1'b0;
    if (wr1_ok) pend_d[bus.wa1] = 1'b0;
    if (res_ok) pend_d[bus.res_addr] = 1'b1;
  end

  // Control FSM: clear walk after reset, then scoreboard updates in idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      pend_q    <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          pend_q <= pend_d;
        end
      endcase
    end
  end

  // Storage array: clear walk, or the two write ports with port 1 landing last
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else begin
        if (wr0_ok) mem_q[bus.wa0] <= bus.wd0;
        if (wr1_ok) mem_q[bus.wa1] <= bus.wd1;
      end
    end
  end

  // Asynchronous read ports with scoreboard lookup; silenced while clearing
  always_comb begin
    bus.rd1   = '0;
    bus.pend1 = 1'b0;
    bus.rd2   = '0;
    bus.pend2 = 1'b0;
    if (!busy_q && !(ZR && (bus.rs == '0))) begin
      bus.rd1   = mem_q[bus.rs];
      bus.pend1 = pend_q[bus.rs];
`ifdef GPR_BYPASS_EN
      if (wr1_ok && (bus.wa1 == bus.rs)) begin
        bus.rd1   = bus.wd1;
        bus.pend1 = res_ok && (bus.res_addr == bus.rs);
      end else if (wr0_ok && (bus.wa0 == bus.rs)) begin
        bus.rd1   = bus.wd0;
        bus.pend1 = res_ok && (bus.res_addr == bus.rs);
      end
`endif
    end
    if (!busy_q && !(ZR && (bus.rt == '0))) begin
      bus.rd2   = mem_q[bus.rt];
      bus.pend2 = pend_q[bus.rt];
`ifdef GPR_BYPASS_EN
      if (wr1_ok && (bus.wa1 == bus.rt)) begin
        bus.rd2   = bus.wd1;
        bus.pend2 = res_ok && (bus.res_addr == bus.rt);
      end else if (wr0_ok && (bus.wa0 == bus.rt)) begin
        bus.rd2   = bus.wd0;
        bus.pend2 = res_ok && (bus.res_addr == bus.rt);
      end
`endif
    end
  end

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_gpr_file_mp.sv
// Self-checking bench for gpr_file_mp: directed stimulus, literal checks and
// a per-cycle comparison against a behavioural model of the register file.
module tb_gpr_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpr_file_mp_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The clear walk is hidden behind busy, so the model only tracks how many
  // clearing cycles remain and wipes its whole array when that reaches zero.
  logic [31:0] mdl_mem [32];
  logic        mdl_pend [32];
  int          mdl_rem = 0;
  bit          mdl_valid = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_valid = 1;
      mdl_rem   = 32;
      for (int i = 0; i < 32; i++) mdl_pend[i] = 1'b0;
    end else if (mdl_valid) begin
      if (mdl_rem > 0) begin
        mdl_rem--;
        if (mdl_rem == 0)
          for (int i = 0; i < 32; i++) mdl_mem[i] = 32'h0;
      end else begin
        if (bus.we0 && bus.wa0 != 0) mdl_mem[bus.wa0] = bus.wd0;
        if (bus.we1 && bus.wa1 != 0) mdl_mem[bus.wa1] = bus.wd1;
        if (bus.we0) mdl_pend[bus.wa0] = 1'b0;
        if (bus.we1) mdl_pend[bus.wa1] = 1'b0;
        if (bus.res_en && bus.res_addr != 0) mdl_pend[bus.res_addr] = 1'b1;
      end
    end
  end

  function automatic void mdl_port(input logic [4:0] a, output logic [31:0] d, output logic p);
    d = 32'h0;
    p = 1'b0;
    if (mdl_rem == 0 && a != 0) begin
      d = mdl_mem[a];
      p = mdl_pend[a];
`ifdef GPR_BYPASS_EN
      if (bus.we1 && bus.wa1 == a) begin
        d = bus.wd1;
        p = bus.res_en && bus.res_addr == a;
      end else if (bus.we0 && bus.wa0 == a) begin
        d = bus.wd0;
        p = bus.res_en && bus.res_addr == a;
      end
`endif
    end
  endfunction

  // Compare DUT outputs against the model every cycle once reset has been seen
  always @(negedge clk) begin
    logic [31:0] e_d1, e_d2;
    logic        e_p1, e_p2;
    if (mdl_valid) begin
      mdl_port(bus.rs, e_d1, e_p1);
      mdl_port(bus.rt, e_d2, e_p2);
      chk("cmp_busy", {31'b0, bus.busy}, {31'b0, (mdl_rem > 0)});
      chk("cmp_rd1", bus.rd1, e_d1);
      chk("cmp_rd2", bus.rd2, e_d2);
      chk("cmp_pend1", {31'b0, bus.pend1}, {31'b0, e_p1});
      chk("cmp_pend2", {31'b0, bus.pend2}, {31'b0, e_p2});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Counts consecutive busy cycles (sampled 3 time units after each edge)
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #3;
    end
  endtask

  task automatic write0(input logic [4:0] a, input logic [31:0] d);
    bus.we0 = 1'b1; bus.wa0 = a; bus.wd0 = d;
    step();
    bus.we0 = 1'b0;
  endtask

  int nb;

  initial begin
    bus.rs = '0; bus.rt = '0;
    bus.we0 = 0; bus.wa0 = '0; bus.wd0 = '0;
    bus.we1 = 0; bus.wa1 = '0; bus.wd1 = '0;
    bus.res_en = 0; bus.res_addr = '0;

    // Initial reset and clear
    rst_n = 1'b0;
    step();
    settle();
    chk("reset_busy", {31'b0, bus.busy}, 32'h1);
    chk("reset_rd1", bus.rd1, 32'h0);
    chk("reset_pend1", {31'b0, bus.pend1}, 32'h0);
    rst_n = 1'b1;
    settle();
    count_busy(nb);
    chk("first_clear_len", nb, 32);

    // Preload, then reset and confirm the walk wipes everything
    write0(5'd5, 32'hA5A5A5A5);
    write0(5'd31, 32'h0BADF00D);
    bus.res_en = 1'b1; bus.res_addr = 5'd12;
    step();
    bus.res_en = 1'b0;
    bus.rs = 5'd31; bus.rt = 5'd12;
    settle();
    chk("preload_rd1", bus.rd1, 32'h0BADF00D);
    chk("preload_pend2", {31'b0, bus.pend2}, 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    settle();
    count_busy(nb);
    chk("clear_len", nb, 32);
    for (int i = 0; i < 32; i++) begin
      bus.rs = 5'(i); bus.rt = 5'(31 - i);
      #1;
      chk("cleared_rd1", bus.rd1, 32'h0);
      chk("cleared_pend1", {31'b0, bus.pend1}, 32'h0);
    end
    step();

    // Basic write/read and zero register
    write0(5'd5, 32'hDEADBEEF);
    bus.rs = 5'd5;
    settle();
    chk("wr5_rd1", bus.rd1, 32'hDEADBEEF);
    write0(5'd0, 32'h1);
    bus.rs = 5'd0;
    settle();
    chk("zero_rd1", bus.rd1, 32'h0);

    // Dual-write collision
    bus.we0 = 1; bus.wa0 = 5'd7; bus.wd0 = 32'hAAAA0000;
    bus.we1 = 1; bus.wa1 = 5'd7; bus.wd1 = 32'h5555FFFF;
    step();
    bus.we0 = 0; bus.we1 = 0;
    bus.rt = 5'd7;
    settle();
    chk("collision_rd2", bus.rd2, 32'h5555FFFF);

    // Scoreboard
    bus.res_en = 1; bus.res_addr = 5'd9;
    step();
    bus.res_en = 0;
    bus.rs = 5'd9; bus.rt = 5'd9;
    settle();
    chk("reserve_pend1", {31'b0, bus.pend1}, 32'h1);
    chk("reserve_pend2", {31'b0, bus.pend2}, 32'h1);
    write0(5'd9, 32'h00000099);
    settle();
    chk("retire_pend1", {31'b0, bus.pend1}, 32'h0);
    bus.res_en = 1; bus.res_addr = 5'd9;
    bus.we1 = 1; bus.wa1 = 5'd9; bus.wd1 = 32'h00000999;
    step();
    bus.res_en = 0; bus.we1 = 0;
    settle();
    chk("res_wins_pend1", {31'b0, bus.pend1}, 32'h1);
    chk("res_wins_rd1", bus.rd1, 32'h00000999);
    bus.res_en = 1; bus.res_addr = 5'd0;
    step();
    bus.res_en = 0; bus.rs = 5'd0;
    settle();
    chk("zero_res_pend1", {31'b0, bus.pend1}, 32'h0);

    // Mid-clear reset with writes attempted while busy
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    settle();
    chk("midclear_busy", {31'b0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.we0 = 1; bus.wa0 = 5'd3; bus.wd0 = 32'h12345678;
    bus.res_en = 1; bus.res_addr = 5'd3;
    settle();
    count_busy(nb);
    bus.we0 = 0; bus.res_en = 0;
    chk("restart_clear_len", nb, 32);
    bus.rs = 5'd3; bus.rt = 5'd5;
    #1;
    chk("blocked_wr_rd1", bus.rd1, 32'h0);
    chk("blocked_res_pend1", {31'b0, bus.pend1}, 32'h0);
    chk("wiped5_rd2", bus.rd2, 32'h0);
    bus.rs = 5'd9;
    #1;
    chk("wiped9_pend1", {31'b0, bus.pend1}, 32'h0);
    step();

    // Same-cycle write and read: forwarded only with the bypass build
    write0(5'd4, 32'h11111111);
    bus.we1 = 1; bus.wa1 = 5'd4; bus.wd1 = 32'hCAFEF00D;
    bus.rs = 5'd4;
    settle();
`ifdef GPR_BYPASS_EN
    chk("samecyc_rd1", bus.rd1, 32'hCAFEF00D);
`else
    chk("samecyc_rd1", bus.rd1, 32'h11111111);
`endif
    step();
    bus.we1 = 0;
    settle();
    chk("after_rd1", bus.rd1, 32'hCAFEF00D);

    // A few mixed cycles for the per-cycle compare
    bus.we0 = 1; bus.wa0 = 5'd20; bus.wd0 = 32'h00002020;
    bus.we1 = 1; bus.wa1 = 5'd21; bus.wd1 = 32'h00002121;
    bus.res_en = 1; bus.res_addr = 5'd22;
    bus.rs = 5'd20; bus.rt = 5'd22;
    step();
    bus.we0 = 0; bus.we1 = 0; bus.res_en = 0;
    bus.rs = 5'd21;
    settle();
    chk("mixed_rd1", bus.rd1, 32'h00002121);
    chk("mixed_pend2", {31'b0, bus.pend2}, 32'h1);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_file_mp.md
Name: gpr_file_mp

Overview:
- Parametrised successor to the single-write general-purpose register file.
- Provides 2 asynchronous read ports and 2 synchronous write ports.
- Clears all entries in hardware after reset with a sequenced walk, and tracks a per-register pending scoreboard for hazard detection.
- Sits in the decode/writeback stage of the pipelined MIPS32 core; the second write port serves a dual-issue or late-writeback path.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes and reserves.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- rs  input  ADDR_W  read port 1 address.
- rt  input  ADDR_W  read port 2 address.
- rd1  output  DATA_W  read port 1 data.
- rd2  output  DATA_W  read port 2 data.
- we0  input  1  write enable, port 0.
- wa0  input  ADDR_W  write address, port 0.
- wd0  input  DATA_W  write data, port 0.
- we1  input  1  write enable, port 1.
- wa1  input  ADDR_W  write address, port 1.
- wd1  input  DATA_W  write data, port 1.
- res_en  input  1  reserve request: mark res_addr pending.
- res_addr  input  ADDR_W  register to reserve.
- pend1  output  1  pending bit of register rs.
- pend2  output  1  pending bit of register rt.
- busy  output  1  clear sequence in progress.

Behaviour:
- Clock is clk. Reset is rst_n, synchronous and active-low, sampled on the rising edge of clk only.
- FSM has two states, CLEAR and IDLE.
- Reset, rst_n=0 at an edge:
  - state <= CLEAR, clr_ptr <= 0, all pending bits <= 0, busy=1.
  - Outputs during and after reset: rd1=rd2=0, pend1=pend2=0, busy=1.
- CLEAR state:
  - Each edge with rst_n=1 writes 0 to entry clr_ptr and increments clr_ptr.
  - On the edge that clears entry DEPTH-1, state <= IDLE.
  - busy is therefore high for exactly DEPTH cycles after rst_n deasserts.
  - While busy=1: we0, we1 and res_en are ignored; rd1, rd2, pend1, pend2 are forced to 0.
  - rst_n=0 mid-clear restarts the sequence with clr_ptr=0.
- IDLE reads:
  - Combinational: rd1=mem[rs], rd2=mem[rt].
  - With ZERO_REG=1, address 0 always reads 0.
- IDLE writes:
  - Take effect at the rising edge.
  - Both ports enabled to the same address: port 1 data wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Scoreboard:
  - res_en sets pending[res_addr] at the edge.
  - Any enabled write clears pending[wa] at the edge.
  - Reserve and write to the same address in the same cycle: the set wins (new producer).
  - With ZERO_REG=1, reserves to address 0 are dropped.
  - pend1=pending[rs] and pend2=pending[rt], combinational.
- No internal stall logic; the consumer uses pend1/pend2 to stall.

Optional Feature:
- Macro GPR_BYPASS_EN.
- When defined, write-through forwarding applies:
  - If rs matches an enabled write address in the same cycle, rd1 returns the write data, with port 1 priority over port 0.
  - pend1 reads 0 for that address unless res_en targets it in the same cycle.
  - Same rules for rt/rd2/pend2.
  - Address 0 is never forwarded when ZERO_REG=1.
  - Forwarding is suppressed while busy=1.
- When not defined, reads return the pre-edge array contents and pending bits; a write is visible only after the edge.

Test Plan:
- Reset clear sequence:
  - Stimulus: preload entries, then hold rst_n=0 for 1 cycle and release.
  - Required: busy stays 1 for exactly 32 cycles. Then every entry reads 0 and all pend bits are 0.
- Basic write/read:
  - Stimulus: we0, wa0=5, wd0=32'hDEADBEEF.
  - Required: next cycle rs=5 gives rd1=32'hDEADBEEF.
  - Stimulus: write 32'h1 to address 0.
  - Required: rd1=0 with rs=0.
- Dual-write collision:
  - Stimulus: we0 and we1 both to address 7, wd0=32'hAAAA0000, wd1=32'h5555FFFF.
  - Required: mem[7]=32'h5555FFFF.
- Scoreboard:
  - Stimulus: res_en, res_addr=9.
  - Required: pend1=1 with rs=9.
  - Stimulus: write to 9.
  - Required: pend1=0.
  - Stimulus: reserve 9 and write 9 in the same cycle.
  - Required: pend1=1 afterwards.
- Mid-clear reset and busy blocking:
  - Stimulus: assert rst_n=0 at clr_ptr=10.
  - Required: busy lasts 32 more cycles from release.
  - Stimulus: we0 to 3 with 32'h12345678 while busy.
  - Required: entry 3 reads 0 after busy falls.
- Bypass (GPR_BYPASS_EN defined):
  - Stimulus: we1 to 4 with 32'hCAFEF00D and rs=4 in the same cycle.
  - Required: rd1=32'hCAFEF00D combinationally.
  - Without the macro, the same stimulus gives the old value in that cycle.
